// File: rtl/sym_pkg.sv
// Shared types, segment-code constants and decode helper for the symbol scorer.
package sym_pkg;

    // Active-low seven-segment codes, bit 7 is the (unlit) decimal point
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hD8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYM,
        ARMED
    } state_t;

    typedef logic [15:0] bcd4_t;

    // Unknown codes (blank included) map to 4'hF, which doubles as the error marker
    function automatic logic [3:0] seg_to_digit(input logic [7:0] seg);
        logic [3:0] d;
        case (seg)
            SEG_0:   d = 4'd0;
            SEG_1:   d = 4'd1;
            SEG_2:   d = 4'd2;
            SEG_3:   d = 4'd3;
            SEG_4:   d = 4'd4;
            SEG_5:   d = 4'd5;
            SEG_6:   d = 4'd6;
            SEG_7:   d = 4'd7;
            SEG_8:   d = 4'd8;
            SEG_9:   d = 4'd9;
            default: d = 4'hF;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// Four-digit BCD counter with synchronous clear and increment, saturating at 9999.
module bcd_sat_counter
    import sym_pkg::*;
(
    input  logic  Clk100M,
    input  logic  Reset,
    input  logic  clr,
    input  logic  inc,
    output bcd4_t count
);

    bcd4_t count_q;
    bcd4_t count_d;
    logic  carry;

    // Ripple a +1 through the BCD digits; 9999 holds
    always_comb begin
        count_d = count_q;
        carry   = 1'b1;
        if (count_q != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        count_d[4*i +: 4] = 4'd0;
                    end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    // Clear wins over increment
    always_ff @(posedge Clk100M) begin
        if (Reset || clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sym_scorer.sv
// Symbol-stream scorer: decodes generated symbols, arms response windows on special
// symbols and scores presses as hits, misses or false presses in saturating BCD.
// Optional feature macro: SYM_SCORER_REACTION_EN (best arm-to-hit reaction time).
module sym_scorer
    import sym_pkg::*;
#(
    parameter int unsigned RESP_WINDOW = 50_000_000
) (
    input  logic        Clk100M,
    input  logic        Reset,
    input  logic        genSym,
    input  logic        generated,
    input  logic        special,
    input  logic [7:0]  generatedSym,
    input  logic        btnPress,
    output logic [15:0] hits,
    output logic [15:0] misses,
    output logic [15:0] falsePresses,
    output logic [3:0]  lastDigit,
    output logic        symErr,
    output logic        pending,
    output logic        hitPulse,
    output logic        missPulse,
    output logic [31:0] bestReaction
);

    localparam logic [31:0] WinLast = 32'(RESP_WINDOW - 1);

    state_t      state_q;
    logic        gensym_q;
    logic [31:0] win_cnt_q;

    logic       rise;
    logic       arm_ev;
    logic       win_end;
    logic       clr_cnt;
    logic       hit_inc;
    logic       miss_inc;
    logic       false_inc;
    logic [3:0] digit;

    // Score events for this cycle; genSym low suppresses everything
    always_comb begin
        rise      = genSym & ~gensym_q;
        arm_ev    = generated & special;
        win_end   = (win_cnt_q == WinLast);
        digit     = seg_to_digit(generatedSym);
        clr_cnt   = rise && (state_q == IDLE);
        false_inc = genSym && (state_q == WAIT_SYM) && btnPress;
        hit_inc   = genSym && (state_q == ARMED) && btnPress;
        miss_inc  = genSym && (state_q == ARMED) && !btnPress && (arm_ev || win_end);
    end

    // Game FSM with registered status outputs
    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            state_q   <= IDLE;
            gensym_q  <= 1'b0;
            win_cnt_q <= '0;
            lastDigit <= 4'hF;
            symErr    <= 1'b0;
            pending   <= 1'b0;
            hitPulse  <= 1'b0;
            missPulse <= 1'b0;
        end else begin
            gensym_q  <= genSym;
            hitPulse  <= hit_inc;
            missPulse <= miss_inc;
            if (!genSym) begin
                // Open window is dropped unscored
                state_q <= IDLE;
                pending <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= WAIT_SYM;
                            symErr  <= 1'b0;
                        end
                    end
                    WAIT_SYM: begin
                        if (arm_ev) begin
                            state_q   <= ARMED;
                            win_cnt_q <= '0;
                            pending   <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (arm_ev) begin
                            // Old window already scored above; restart a fresh one
                            win_cnt_q <= '0;
                        end else if (btnPress || win_end) begin
                            state_q <= WAIT_SYM;
                            pending <= 1'b0;
                        end else begin
                            win_cnt_q <= win_cnt_q + 32'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            // Decode every symbol; an error recorded here outlives a same-cycle clear
            if (generated) begin
                lastDigit <= digit;
                if (digit == 4'hF) begin
                    symErr <= 1'b1;
                end
            end
        end
    end

`ifdef SYM_SCORER_REACTION_EN
    // Track the fastest arm-to-hit time of the current game
    always_ff @(posedge Clk100M) begin
        if (Reset || clr_cnt) begin
            bestReaction <= 32'hFFFF_FFFF;
        end else if (hit_inc && ((win_cnt_q + 32'd1) < bestReaction)) begin
            bestReaction <= win_cnt_q + 32'd1;
        end
    end
`else
    assign bestReaction = 32'd0;
`endif

    bcd_sat_counter u_hits (
        .Clk100M (Clk100M),
        .Reset   (Reset),
        .clr     (clr_cnt),
        .inc     (hit_inc),
        .count   (hits)
    );

    bcd_sat_counter u_misses (
        .Clk100M (Clk100M),
        .Reset   (Reset),
        .clr     (clr_cnt),
        .inc     (miss_inc),
        .count   (misses)
    );

    bcd_sat_counter u_false (
        .Clk100M (Clk100M),
        .Reset   (Reset),
        .clr     (clr_cnt),
        .inc     (false_inc),
        .count   (falsePresses)
    );

endmodule

// File: tb/tb_sym_scorer.sv
// Directed bench for sym_scorer; window shortened to 150 cycles.
module tb_sym_scorer;

    localparam int unsigned WIN = 150;

    logic        Clk100M = 1'b0;
    logic        Reset = 1'b1;
    logic        genSym = 1'b0;
    logic        generated = 1'b0;
    logic        special = 1'b0;
    logic [7:0]  generatedSym = 8'hFF;
    logic        btnPress = 1'b0;
    logic [15:0] hits, misses, falsePresses;
    logic [3:0]  lastDigit;
    logic        symErr, pending, hitPulse, missPulse;
    logic [31:0] bestReaction;

    int checks = 0;
    int errors = 0;
    int hit_seen = 0;

    sym_scorer #(.RESP_WINDOW(WIN)) dut (
        .Clk100M      (Clk100M),
        .Reset        (Reset),
        .genSym       (genSym),
        .generated    (generated),
        .special      (special),
        .generatedSym (generatedSym),
        .btnPress     (btnPress),
        .hits         (hits),
        .misses       (misses),
        .falsePresses (falsePresses),
        .lastDigit    (lastDigit),
        .symErr       (symErr),
        .pending      (pending),
        .hitPulse     (hitPulse),
        .missPulse    (missPulse),
        .bestReaction (bestReaction)
    );

    always #5 Clk100M = ~Clk100M;

    always @(negedge Clk100M) if (hitPulse === 1'b1) hit_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required run to finish");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge Clk100M);
    endtask

    task automatic sym(input logic [7:0] code, input logic spec, input logic press);
        generated = 1'b1; special = spec; generatedSym = code; btnPress = press;
        cyc(1);
        generated = 1'b0; special = 1'b0; btnPress = 1'b0;
    endtask

    task automatic press();
        btnPress = 1'b1;
        cyc(1);
        btnPress = 1'b0;
    endtask

    task automatic new_game();
        genSym = 1'b0;
        cyc(1);
        genSym = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        cyc(3);
        Reset = 1'b0;
        checks++; if ({hits, misses, falsePresses} !== 48'h0) begin
            errors++; $display("FAIL reset_counts got %h %h %h want 0000", hits, misses, falsePresses); end
        checks++; if (lastDigit !== 4'hF) begin
            errors++; $display("FAIL reset_digit got %h want f", lastDigit); end
        checks++; if ({symErr, pending, hitPulse, missPulse} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {symErr, pending, hitPulse, missPulse}); end
`ifdef SYM_SCORER_REACTION_EN
        checks++; if (bestReaction !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_best got %h want ffffffff", bestReaction); end
`else
        checks++; if (bestReaction !== 32'h0) begin
            errors++; $display("FAIL reset_best got %h want 0", bestReaction); end
`endif
    endtask

    task automatic test_hit();
        int h0;
        new_game();
        sym(8'hD8, 1'b1, 1'b0);
        checks++; if (lastDigit !== 4'd7 || pending !== 1'b1) begin
            errors++; $display("FAIL hit_arm got digit %h pending %b want 7 1", lastDigit, pending); end
        h0 = hit_seen;
        cyc(99);
        press();
        checks++; if (hits !== 16'h0001 || hitPulse !== 1'b1 || pending !== 1'b0) begin
            errors++; $display("FAIL hit_score got %h pulse %b pending %b want 0001 1 0", hits, hitPulse, pending); end
        cyc(2);
        checks++; if (hit_seen - h0 !== 1 || pending !== 1'b0) begin
            errors++; $display("FAIL hit_once got %0d pulses pending %b want 1 0", hit_seen - h0, pending); end
    endtask

    task automatic test_window_end();
        new_game();
        sym(8'hC0, 1'b1, 1'b0);
        cyc(WIN - 1);
        checks++; if (missPulse !== 1'b0 || misses !== 16'h0 || pending !== 1'b1) begin
            errors++; $display("FAIL miss_early got %b %h %b want 0 0000 1", missPulse, misses, pending); end
        cyc(1);
        checks++; if (missPulse !== 1'b1 || misses !== 16'h0001 || pending !== 1'b0) begin
            errors++; $display("FAIL miss_end got %b %h %b want 1 0001 0", missPulse, misses, pending); end
        sym(8'hC0, 1'b1, 1'b0);
        cyc(WIN - 1);
        press();
        checks++; if (hits !== 16'h0001 || misses !== 16'h0001 || hitPulse !== 1'b1) begin
            errors++; $display("FAIL final_cycle_hit got %h %h %b want 0001 0001 1", hits, misses, hitPulse); end
    endtask

    task automatic test_false_press();
        new_game();
        press();
        checks++; if (falsePresses !== 16'h0001) begin
            errors++; $display("FAIL false_one got %h want 0001", falsePresses); end
        sym(8'hF9, 1'b1, 1'b1);
        checks++; if (falsePresses !== 16'h0002 || pending !== 1'b1 || hits !== 16'h0) begin
            errors++; $display("FAIL false_arm got %h %b %h want 0002 1 0000", falsePresses, pending, hits); end
    endtask

    task automatic test_rearm();
        new_game();
        sym(8'hA4, 1'b1, 1'b0);
        cyc(5);
        sym(8'hB0, 1'b1, 1'b0);
        checks++; if (misses !== 16'h0001 || missPulse !== 1'b1 || pending !== 1'b1) begin
            errors++; $display("FAIL rearm_miss got %h %b %b want 0001 1 1", misses, missPulse, pending); end
        cyc(WIN - 5);
        checks++; if (pending !== 1'b1 || misses !== 16'h0001) begin
            errors++; $display("FAIL rearm_restart got %b %h want 1 0001", pending, misses); end
        sym(8'h92, 1'b1, 1'b1);
        checks++; if (hits !== 16'h0001 || misses !== 16'h0001 || pending !== 1'b1) begin
            errors++; $display("FAIL rearm_hit got %h %h %b want 0001 0001 1", hits, misses, pending); end
        cyc(3);
        genSym = 1'b0;
        cyc(2);
        checks++; if (pending !== 1'b0 || hits !== 16'h0001 || misses !== 16'h0001) begin
            errors++; $display("FAIL drop_window got %b %h %h want 0 0001 0001", pending, hits, misses); end
    endtask

    task automatic test_sym_err();
        new_game();
        sym(8'hA5, 1'b0, 1'b0);
        checks++; if (lastDigit !== 4'hF || symErr !== 1'b1 || pending !== 1'b0) begin
            errors++; $display("FAIL err_set got %h %b %b want f 1 0", lastDigit, symErr, pending); end
        sym(8'h99, 1'b0, 1'b0);
        checks++; if (lastDigit !== 4'd4 || symErr !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %h %b want 4 1", lastDigit, symErr); end
        new_game();
        checks++; if (symErr !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b want 0", symErr); end
    endtask

    task automatic test_reset_mid();
        new_game();
        sym(8'h80, 1'b1, 1'b0);
        cyc(3);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        checks++; if (pending !== 1'b0 || misses !== 16'h0 || missPulse !== 1'b0 || hits !== 16'h0) begin
            errors++; $display("FAIL reset_mid got %b %h %b %h want 0 0000 0 0000", pending, misses, missPulse, hits); end
    endtask

    task automatic test_saturate();
        new_game();
        for (int i = 0; i < 9999; i++) begin
            sym(8'h90, 1'b1, 1'b0);
            press();
            if (i == 9) begin
                checks++; if (hits !== 16'h0010) begin
                    errors++; $display("FAIL bcd_carry got %h want 0010", hits); end
            end
        end
        checks++; if (hits !== 16'h9999) begin
            errors++; $display("FAIL sat_reach got %h want 9999", hits); end
        sym(8'h90, 1'b1, 1'b0);
        press();
        checks++; if (hits !== 16'h9999) begin
            errors++; $display("FAIL sat_hold got %h want 9999", hits); end
    endtask

    task automatic test_reaction();
        new_game();
        sym(8'h82, 1'b1, 1'b0);
        cyc(39);
        press();
        sym(8'h82, 1'b1, 1'b0);
        cyc(24);
        press();
`ifdef SYM_SCORER_REACTION_EN
        checks++; if (bestReaction !== 32'd25 || hits !== 16'h0002) begin
            errors++; $display("FAIL reaction got %0d hits %h want 25 0002", bestReaction, hits); end
`else
        checks++; if (bestReaction !== 32'd0 || hits !== 16'h0002) begin
            errors++; $display("FAIL reaction got %0d hits %h want 0 0002", bestReaction, hits); end
`endif
    endtask

    initial begin
        test_reset();
        test_hit();
        test_window_end();
        test_false_press();
        test_rearm();
        test_sym_err();
        test_reset_mid();
        test_reaction();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
